// File: rtl/main_mem_responder_pkg.sv
// Shared definitions for the main-memory responder: bus widths and the
// transfer FSM encoding.
package mem_if_pkg;
    localparam int BLOCK_BITS = 256;
    localparam int ADDR_W     = 16;
    localparam int OFFSET_W   = 5;
    localparam int LAT_W      = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;
endpackage

// File: rtl/main_mem_responder_if.sv
// Cache main-memory port: requester drives the request, responder returns
// block data and the completion/status pulses.
interface main_mem_if;
    import mem_if_pkg::*;

    logic                  mainMaccess;
    logic                  mainRead;
    logic                  mainWrite;
    logic [ADDR_W-1:0]     address;
    logic [BLOCK_BITS-1:0] wblock;
    logic [BLOCK_BITS-1:0] rblock;
    logic                  mainMready;
    logic                  busy;
    logic                  protoErr;

    modport master (
        output mainMaccess, mainRead, mainWrite, address, wblock,
        input  rblock, mainMready, busy, protoErr
    );

    modport slave (
        input  mainMaccess, mainRead, mainWrite, address, wblock,
        output rblock, mainMready, busy, protoErr
    );
endinterface

// File: rtl/main_mem_responder_mem_block_array.sv
// Single-port block store with synchronous write and registered read.
// Only the read register is reset; the array keeps its contents.
module mem_block_array #(
    parameter int DEPTH_LOG2 = 6,
    parameter int WIDTH      = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [WIDTH-1:0]      wdata,
    output logic [WIDTH-1:0]      rdata
);
    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (en && we)
            mem[idx] <= wdata;
    end

    // rdata only moves on a read, so it holds the last read block
    always_ff @(posedge clk) begin
        if (reset)
            rdata <= '0;
        else if (en && !we)
            rdata <= mem[idx];
    end
endmodule

// File: rtl/main_mem_responder.sv
// Block-transfer responder: accepts one read/write per request, completes it
// LATENCY cycles after acceptance, then waits for the requester to drop access.
module main_mem_responder
    import mem_if_pkg::*;
#(
    parameter int DEPTH_LOG2 = 6,
    parameter int LATENCY    = 4
) (
    input logic     clk,
    input logic     reset,
    main_mem_if.slave bus
);
    localparam logic [LAT_W-1:0] CNT_INIT = LAT_W'(LATENCY - 1);

    state_e                state, next;
    logic [LAT_W-1:0]      cnt;
    logic                  op_write;
    logic [DEPTH_LOG2-1:0] idx;
    logic [BLOCK_BITS-1:0] wdata_q;
    logic [BLOCK_BITS-1:0] rdata;
    logic                  legal, illegal, accept, mem_en, proto_err_q;

    assign legal   = bus.mainMaccess && (bus.mainRead != bus.mainWrite);
    assign illegal = bus.mainMaccess && (bus.mainRead == bus.mainWrite);

    // The array access is issued on the edge entering RESP so registered read
    // data lines up with mainMready; reset suppresses a pending write.
    always_comb begin
        next   = state;
        accept = 1'b0;
        mem_en = 1'b0;
        case (state)
            IDLE: if (legal) begin
                next   = WAIT;
                accept = 1'b1;
            end
            WAIT: if (cnt == '0) begin
                next   = RESP;
                mem_en = !reset;
            end
            RESP: next = DONE;
            DONE: if (!bus.mainMaccess) next = IDLE;
            default: next = IDLE;
        endcase
    end

    // LATENCY=1 loads cnt=0, so WAIT lasts a single cycle and mainMready
    // still lands one edge after acceptance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state       <= next;
            proto_err_q <= (state == IDLE) && illegal;
            if (accept)
                cnt <= CNT_INIT;
            else if (state == WAIT && cnt != '0)
                cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_write <= bus.mainWrite;
            idx      <= bus.address[OFFSET_W+DEPTH_LOG2-1:OFFSET_W];
            wdata_q  <= bus.wblock;
        end
    end

    mem_block_array #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (BLOCK_BITS)
    ) u_store (
        .clk   (clk),
        .reset (reset),
        .en    (mem_en),
        .we    (op_write),
        .idx   (idx),
        .wdata (wdata_q),
        .rdata (rdata)
    );

    assign bus.rblock     = rdata;
    assign bus.mainMready = (state == RESP);
    assign bus.busy       = (state != IDLE);
    assign bus.protoErr   = proto_err_q;
endmodule

// File: tb/tb_main_mem_responder.sv
// Directed bench for main_mem_responder at LATENCY 4, 1 and 255.
module tb_main_mem_responder;
    import mem_if_pkg::*;

    localparam logic [BLOCK_BITS-1:0] PAT_A5 = {32{8'hA5}};
    localparam logic [BLOCK_BITS-1:0] PAT_11 = {32{8'h11}};
    localparam logic [BLOCK_BITS-1:0] PAT_22 = {32{8'h22}};
    localparam logic [BLOCK_BITS-1:0] PAT_44 = {32{8'h44}};
    localparam logic [BLOCK_BITS-1:0] PAT_55 = {32{8'h55}};
    localparam logic [BLOCK_BITS-1:0] PAT_66 = {32{8'h66}};
    localparam logic [BLOCK_BITS-1:0] PAT_77 = {32{8'h77}};
    localparam int LIMIT = 300;

    logic clk = 1'b0;
    logic reset;
    logic access, rd, wr;
    logic [ADDR_W-1:0]     addr;
    logic [BLOCK_BITS-1:0] wdata;
    int sel;
    int errors = 0;
    int checks = 0;

    logic                  mready_s, busy_s, perr_s;
    logic [BLOCK_BITS-1:0] rblock_s;

    always #5 clk = ~clk;

    main_mem_if if4 ();
    main_mem_if if1 ();
    main_mem_if if255 ();

    assign if4.mainMaccess   = access && (sel == 0);
    assign if1.mainMaccess   = access && (sel == 1);
    assign if255.mainMaccess = access && (sel == 2);
    assign if4.mainRead   = rd;  assign if1.mainRead   = rd;  assign if255.mainRead   = rd;
    assign if4.mainWrite  = wr;  assign if1.mainWrite  = wr;  assign if255.mainWrite  = wr;
    assign if4.address    = addr; assign if1.address   = addr; assign if255.address   = addr;
    assign if4.wblock     = wdata; assign if1.wblock   = wdata; assign if255.wblock   = wdata;

    main_mem_responder #(.LATENCY(4))   dut4   (.clk(clk), .reset(reset), .bus(if4));
    main_mem_responder #(.LATENCY(1))   dut1   (.clk(clk), .reset(reset), .bus(if1));
    main_mem_responder #(.LATENCY(255)) dut255 (.clk(clk), .reset(reset), .bus(if255));

    always_comb begin
        mready_s = if4.mainMready;
        busy_s   = if4.busy;
        perr_s   = if4.protoErr;
        rblock_s = if4.rblock;
        if (sel == 1) begin
            mready_s = if1.mainMready; busy_s = if1.busy;
            perr_s   = if1.protoErr;   rblock_s = if1.rblock;
        end else if (sel == 2) begin
            mready_s = if255.mainMready; busy_s = if255.busy;
            perr_s   = if255.protoErr;   rblock_s = if255.rblock;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: measure latency, hold access for `hold` cycles
    // (>=1) after mainMready, then drop it and confirm return to idle.
    task automatic do_req(input int s, input logic w, input logic [ADDR_W-1:0] a,
                          input logic [BLOCK_BITS-1:0] d, input int hold,
                          input int exp_lat, input string nm);
        int n = -1;
        int busy_low = 0;
        int extra = 0;
        sel = s; addr = a; wdata = d; wr = w; rd = !w; access = 1'b1;
        for (int k = 0; k < LIMIT; k++) begin
            tick();
            if (mready_s) begin n = k; break; end
            if (!busy_s) busy_low++;
        end
        checks++;
        if (n !== exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d want %0d", nm, n, exp_lat);
        end
        for (int h = 0; h < hold; h++) begin
            tick();
            if (mready_s) extra++;
            if (!busy_s) busy_low++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL %s_single_pulse: extra pulses %0d want 0", nm, extra);
        end
        checks++;
        if (busy_low !== 0) begin
            errors++;
            $display("FAIL %s_busy_held: busy low %0d cycles want 0", nm, busy_low);
        end
        access = 1'b0; rd = 1'b0; wr = 1'b0;
        tick();
        checks++;
        if (busy_s !== 1'b0 || mready_s !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b mready=%b want 0 0", nm, busy_s, mready_s);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; access = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; sel = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            checks++;
            if ({mready_s, busy_s, perr_s} !== 3'b000 || rblock_s !== '0) begin
                errors++;
                $display("FAIL reset_state[%0d]: mready=%b busy=%b perr=%b rblock=%h want 0",
                         s, mready_s, busy_s, perr_s, rblock_s[31:0]);
            end
        end
        tick();
    endtask

    task automatic test_write_latency();
        do_req(0, 1'b1, 16'h1000, PAT_A5, 2, 4, "wr_a5");
    endtask

    task automatic test_read();
        do_req(0, 1'b0, 16'h1000, '0, 1, 4, "rd_a5");
        repeat (3) tick();
        checks++;
        if (rblock_s !== PAT_A5) begin
            errors++;
            $display("FAIL read_held: got %h want %h", rblock_s, PAT_A5);
        end
    endtask

    task automatic test_alias();
        do_req(0, 1'b1, 16'h0020, PAT_11, 1, 4, "wr_11");
        checks++;
        if (rblock_s !== PAT_A5) begin
            errors++;
            $display("FAIL write_keeps_rblock: got %h want %h", rblock_s, PAT_A5);
        end
        do_req(0, 1'b1, 16'h0820, PAT_22, 1, 4, "wr_22");
        do_req(0, 1'b0, 16'h0020, '0, 1, 4, "rd_alias");
        checks++;
        if (rblock_s !== PAT_22) begin
            errors++;
            $display("FAIL alias_read: got %h want %h", rblock_s, PAT_22);
        end
    endtask

    task automatic test_proto_err();
        int pulses = 0;
        int rdy = 0;
        int bsy = 0;
        sel = 0; addr = 16'h1000; wdata = PAT_77; rd = 1'b1; wr = 1'b1; access = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (perr_s) pulses++;
            if (mready_s) rdy++;
            if (busy_s) bsy++;
            if (k == 2) begin access = 1'b0; rd = 1'b0; wr = 1'b0; end
        end
        checks++;
        if (pulses !== 3 || rdy !== 0 || bsy !== 0) begin
            errors++;
            $display("FAIL proto_err_both: pulses=%0d mready=%0d busy=%0d want 3 0 0", pulses, rdy, bsy);
        end
        pulses = 0;
        access = 1'b1;
        tick();
        if (perr_s) pulses++;
        access = 1'b0;
        repeat (2) begin tick(); if (perr_s) pulses++; end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL proto_err_none: pulses=%0d want 1", pulses);
        end
        do_req(0, 1'b0, 16'h1000, '0, 1, 4, "rd_after_err");
        checks++;
        if (rblock_s !== PAT_A5) begin
            errors++;
            $display("FAIL store_unchanged: got %h want %h", rblock_s, PAT_A5);
        end
    endtask

    task automatic test_reset_abort();
        int rdy = 0;
        do_req(0, 1'b1, 16'h1040, PAT_44, 1, 4, "wr_44");
        sel = 0; addr = 16'h1040; wdata = PAT_55; wr = 1'b1; rd = 1'b0; access = 1'b1;
        tick();
        tick();
        reset = 1'b1; access = 1'b0; wr = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (mready_s) rdy++;
            if (k == 1) reset = 1'b0;
        end
        checks++;
        if (rdy !== 0 || busy_s !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_ready: mready=%0d busy=%b want 0 0", rdy, busy_s);
        end
        do_req(0, 1'b0, 16'h1040, '0, 1, 4, "rd_abort");
        checks++;
        if (rblock_s !== PAT_44) begin
            errors++;
            $display("FAIL abort_old_data: got %h want %h", rblock_s, PAT_44);
        end
    endtask

    task automatic test_back_to_back_hold();
        do_req(0, 1'b1, 16'h0040, PAT_66, 20, 4, "hold20");
        do_req(0, 1'b0, 16'h0040, '0, 1, 4, "rd_hold");
        checks++;
        if (rblock_s !== PAT_66) begin
            errors++;
            $display("FAIL hold_data: got %h want %h", rblock_s, PAT_66);
        end
    endtask

    task automatic test_latency_sweep();
        do_req(1, 1'b1, 16'h0060, PAT_77, 1, 1, "lat1_wr");
        do_req(1, 1'b0, 16'h0060, '0, 1, 1, "lat1_rd");
        checks++;
        if (rblock_s !== PAT_77) begin
            errors++;
            $display("FAIL lat1_data: got %h want %h", rblock_s, PAT_77);
        end
        do_req(2, 1'b1, 16'h0080, PAT_55, 1, 255, "lat255_wr");
        do_req(2, 1'b0, 16'h0080, '0, 1, 255, "lat255_rd");
        checks++;
        if (rblock_s !== PAT_55) begin
            errors++;
            $display("FAIL lat255_data: got %h want %h", rblock_s, PAT_55);
        end
    endtask

    initial begin
        test_reset();
        test_write_latency();
        test_read();
        test_alias();
        test_proto_err();
        test_reset_abort();
        test_back_to_back_hold();
        test_latency_sweep();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
